// File: rtl/alu_console_ctrl.sv
// alu_console_ctrl: board console for ALU bring-up: debounced buttons, digit entry, paged result on LEDs.
// Build macro ALU_CONSOLE_FLAGS_PAGE_EN appends one LED page showing the captured {N,Z,C} flags.
module alu_console_ctrl #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned SW_W         = 4,
  parameter int unsigned LED_W        = 4,
  parameter int unsigned CTRL_W       = 6,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SW_W-1:0]   sw,
  input  logic [3:0]        btn,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] result,
  input  logic [2:0]        nzc,
  output logic [LED_W-1:0]  led,
  output logic [2:0]        state_o
);

  localparam int unsigned NBTN    = 4;
  localparam int unsigned NDPAGES = DATA_W / LED_W;
`ifdef ALU_CONSOLE_FLAGS_PAGE_EN
  localparam int unsigned NPAGES  = NDPAGES + 1;
`else
  localparam int unsigned NPAGES  = NDPAGES;
`endif
  localparam int unsigned PG_W    = (NPAGES > 1) ? $clog2(NPAGES) : 1;
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYC);

  typedef enum logic [2:0] {
    S_OP   = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_e;

  logic [NBTN-1:0]            sync1_q, sync2_q;
  logic [NBTN-1:0]            deb_q, deb_d;
  logic [NBTN-1:0]            deb_prev_q;
  logic [NBTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NBTN-1:0]            press_c;
  logic                       ev_digit, ev_next, ev_page, ev_clear;

  state_e                     state_q, state_d;
  logic [DATA_W-1:0]          a_q, a_d;
  logic [DATA_W-1:0]          b_q, b_d;
  logic [CTRL_W-1:0]          ctrl_q, ctrl_d;
  logic [DATA_W-1:0]          cap_res_q, cap_res_d;
  logic [2:0]                 cap_nzc_q, cap_nzc_d;
  logic [PG_W-1:0]            page_q, page_d;
  logic [LED_W-1:0]           led_q, led_d;

  // Debounce: the accepted level flips only after DEBOUNCE_CYC consecutive disagreeing samples.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < int'(NBTN); i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press_c  = deb_q & ~deb_prev_q;
  assign ev_digit = press_c[0];
  assign ev_next  = press_c[1];
  assign ev_page  = press_c[2];
  assign ev_clear = press_c[3];

  // Console FSM, event priority clear > next > digit > page.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    ctrl_d    = ctrl_q;
    cap_res_d = cap_res_q;
    cap_nzc_d = cap_nzc_q;
    page_d    = page_q;
    led_d     = led_q;

    if (ev_clear) begin
      a_d     = '0;
      b_d     = '0;
      ctrl_d  = '0;
      page_d  = '0;
      state_d = S_OP;
    end else if (state_q == S_EXEC) begin
      cap_res_d = result;
      cap_nzc_d = nzc;
      page_d    = '0;
      state_d   = S_SHOW;
    end else if (ev_next) begin
      case (state_q)
        S_OP:    state_d = S_A;
        S_A:     state_d = S_B;
        S_B:     state_d = S_EXEC;
        S_SHOW: begin
          state_d = S_A;
          a_d     = '0;
          b_d     = '0;
        end
        default: state_d = S_OP;
      endcase
    end else if (ev_digit) begin
      case (state_q)
        S_OP:    ctrl_d = CTRL_W'({ctrl_q, sw});
        S_A:     a_d    = DATA_W'({a_q, sw});
        S_B:     b_d    = DATA_W'({b_q, sw});
        default: ;
      endcase
    end else if (ev_page && state_q == S_SHOW) begin
      page_d = (page_q == PG_W'(NPAGES - 1)) ? '0 : page_q + PG_W'(1);
    end

    // LED follows the next-state view so it lands one cycle after its cause.
    case (state_d)
      S_OP:   led_d = LED_W'(ctrl_d);
      S_A:    led_d = LED_W'(a_d);
      S_B:    led_d = LED_W'(b_d);
      S_SHOW: begin
`ifdef ALU_CONSOLE_FLAGS_PAGE_EN
        if (page_d == PG_W'(NPAGES - 1)) begin
          led_d = LED_W'(cap_nzc_d);
        end else begin
          led_d = LED_W'(cap_res_d >> (32'(page_d) * LED_W));
        end
`else
        led_d = LED_W'(cap_res_d >> (32'(page_d) * LED_W));
`endif
      end
      default: led_d = led_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
      state_q    <= S_OP;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      cap_res_q  <= '0;
      cap_nzc_q  <= '0;
      page_q     <= '0;
      led_q      <= '0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ctrl_q     <= ctrl_d;
      cap_res_q  <= cap_res_d;
      cap_nzc_q  <= cap_nzc_d;
      page_q     <= page_d;
      led_q      <= led_d;
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = ctrl_q;
  assign led      = led_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_alu_console_ctrl.sv
// Bench for alu_console_ctrl: directed scenarios plus random button traffic against a console model.
// Honours ALU_CONSOLE_FLAGS_PAGE_EN for the extra flag page.
`timescale 1ns/1ps
module tb_alu_console_ctrl;

  localparam int DB = 4;
`ifdef ALU_CONSOLE_FLAGS_PAGE_EN
  localparam int NPAGES = 9;
`else
  localparam int NPAGES = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sw = '0;
  logic [3:0]  btn = '0;
  logic [31:0] alu_a, alu_b, result;
  logic [5:0]  alu_ctrl;
  logic [2:0]  nzc;
  logic [3:0]  led;
  logic [2:0]  state_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_console_ctrl #(.DATA_W(32), .SW_W(4), .LED_W(4), .CTRL_W(6), .DEBOUNCE_CYC(DB)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .result(result), .nzc(nzc), .led(led), .state_o(state_o)
  );

  // Stand-in ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, otherwise pass A. Returns {N,Z,C,result}.
  function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
    logic [32:0] s;
    case (op)
      6'd0:    s = {1'b0, a} + {1'b0, b};
      6'd1:    s = {1'b0, a} - {1'b0, b};
      6'd2:    s = {1'b0, a & b};
      6'd3:    s = {1'b0, a | b};
      6'd4:    s = {1'b0, a ^ b};
      default: s = {1'b0, a};
    endcase
    return {s[31], (s[31:0] == 32'd0), s[32], s[31:0]};
  endfunction

  assign {nzc, result} = alu_fn(alu_a, alu_b, alu_ctrl);

  // Console model: state 0=OP 1=A 2=B 4=SHOW (EXEC is passed through instantly).
  int          m_state;
  int          m_page;
  logic [31:0] m_a, m_b, m_cap;
  logic [5:0]  m_ctrl;
  logic [2:0]  m_f;

  task automatic model_reset();
    m_state = 0; m_page = 0; m_a = '0; m_b = '0; m_cap = '0; m_ctrl = '0; m_f = '0;
  endtask

  task automatic model_apply(input logic [3:0] m, input logic [3:0] d);
    if (m[3]) begin
      m_a = '0; m_b = '0; m_ctrl = '0; m_page = 0; m_state = 0;
    end else if (m[1]) begin
      case (m_state)
        0: m_state = 1;
        1: m_state = 2;
        2: begin {m_f, m_cap} = alu_fn(m_a, m_b, m_ctrl); m_page = 0; m_state = 4; end
        default: begin m_state = 1; m_a = '0; m_b = '0; end
      endcase
    end else if (m[0]) begin
      case (m_state)
        0: m_ctrl = 6'(32'(m_ctrl) * 16 + 32'(d));
        1: m_a = m_a * 16 + 32'(d);
        2: m_b = m_b * 16 + 32'(d);
        default: ;
      endcase
    end else if (m[2] && m_state == 4) begin
      m_page = (m_page + 1) % NPAGES;
    end
  endtask

  function automatic logic [3:0] exp_led();
    case (m_state)
      0: return m_ctrl[3:0];
      1: return 4'(m_a % 16);
      2: return 4'(m_b % 16);
      default: return (m_page < 8) ? 4'(m_cap >> (4 * m_page)) : {1'b0, m_f};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/state"}, 32'(state_o), 32'(m_state));
    chk({tag, "/alu_a"}, alu_a, m_a);
    chk({tag, "/alu_b"}, alu_b, m_b);
    chk({tag, "/alu_ctrl"}, 32'(alu_ctrl), 32'(m_ctrl));
    chk({tag, "/led"}, 32'(led), 32'(exp_led()));
  endtask

  // Clean press: held and released long enough to pass the debouncer, then the model is advanced.
  task automatic press(input logic [3:0] m, input logic [3:0] d);
    sw = d;
    btn = m;
    repeat (DB + 4) @(negedge clk);
    btn = '0;
    repeat (DB + 4) @(negedge clk);
    model_apply(m, d);
  endtask

  task automatic hold(input logic [3:0] m, input int n);
    btn = m;
    repeat (n) @(negedge clk);
  endtask

  int         exec_cycles = 0;
  logic [3:0] show_led0 = '0;
  logic [2:0] last_st = '0;

  always @(negedge clk) begin
    if (state_o == 3'd3) exec_cycles++;
    if (state_o == 3'd4 && last_st == 3'd3) show_led0 = led;
    last_st = state_o;
  end

  initial begin
    logic [3:0] pg_seq [9];
    int         exec_before;
    pg_seq = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD, 4'hF};
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Asynchronous reset while in S_B with A=0x12
    press(4'b0010, 4'h0);
    press(4'b0001, 4'h1);
    press(4'b0001, 4'h2);
    press(4'b0010, 4'h0);
    check_all("t1_pre");
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async/state", 32'(state_o), 32'd0);
    chk("t1_async/led", 32'(led), 32'd0);
    chk("t1_async/alu_a", alu_a, 32'd0);
    chk("t1_async/alu_b", alu_b, 32'd0);
    chk("t1_async/alu_ctrl", 32'(alu_ctrl), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all("t1_post");

    // Debounce: short glitches ignored, a held press counts once, exactly DB cycles accepted
    press(4'b0010, 4'h0);
    sw = 4'h5;
    hold(4'b0001, 2);
    hold(4'b0000, 10);
    chk("t2_glitch2", alu_a, 32'd0);
    hold(4'b0001, DB - 1);
    hold(4'b0000, 10);
    chk("t2_glitch3", alu_a, 32'd0);
    hold(4'b0001, 10);
    hold(4'b0000, DB - 1);
    hold(4'b0001, 6);
    hold(4'b0000, 10);
    model_apply(4'b0001, 4'h5);
    chk("t2_once", alu_a, 32'h5);
    hold(4'b0001, DB);
    hold(4'b0000, 10);
    model_apply(4'b0001, 4'h5);
    chk("t2_exact", alu_a, 32'h55);
    check_all("t2");

    // Basic flow: op 1 (sub), A=0x12, B=0x3
    press(4'b1000, 4'h0);
    press(4'b0001, 4'h1);
    press(4'b0010, 4'h0);
    press(4'b0001, 4'h1);
    press(4'b0001, 4'h2);
    press(4'b0010, 4'h0);
    press(4'b0001, 4'h3);
    chk("t3/alu_ctrl", 32'(alu_ctrl), 32'h01);
    chk("t3/alu_a", alu_a, 32'h12);
    chk("t3/alu_b", alu_b, 32'h3);
    exec_before = exec_cycles;
    press(4'b0010, 4'h0);
    chk("t3/exec_cycles", 32'(exec_cycles - exec_before), 32'd1);
    chk("t3/show_led0", 32'(show_led0), 32'(exp_led()));
    check_all("t3");

    // Repeat op from S_SHOW, then overflow A with nine digits
    press(4'b0010, 4'h0);
    check_all("t4_next");
    for (int i = 1; i <= 9; i++) press(4'b0001, 4'(i));
    chk("t4/alu_a", alu_a, 32'h23456789);
    check_all("t4");

    // Paging 0xDEADBEEF via pass-A opcode
    press(4'b1000, 4'h0);
    press(4'b0001, 4'h7);
    press(4'b0010, 4'h0);
    press(4'b0001, 4'hD); press(4'b0001, 4'hE); press(4'b0001, 4'hA); press(4'b0001, 4'hD);
    press(4'b0001, 4'hB); press(4'b0001, 4'hE); press(4'b0001, 4'hE); press(4'b0001, 4'hF);
    press(4'b0010, 4'h0);
    press(4'b0100, 4'h0);
    chk("t5/page_outside_show", 32'(led), 32'(exp_led()));
    press(4'b0010, 4'h0);
    chk("t5/page0", 32'(led), 32'(pg_seq[0]));
    for (int i = 1; i <= 8; i++) begin
`ifdef ALU_CONSOLE_FLAGS_PAGE_EN
      if (i == 8) begin
        press(4'b0100, 4'h0);
        chk("t5/flags_page", 32'(led), 32'h4);
      end
`endif
      press(4'b0100, 4'h0);
      chk($sformatf("t5/page%0d", i), 32'(led), 32'(pg_seq[i]));
    end
    press(4'b0001, 4'h9);
    check_all("t5_digit_in_show");

    // Clear and next together in S_A: clear wins
    press(4'b1000, 4'h0);
    press(4'b0010, 4'h0);
    press(4'b0001, 4'h7);
    press(4'b1010, 4'h0);
    chk("t6/state", 32'(state_o), 32'd0);
    chk("t6/alu_a", alu_a, 32'd0);
    check_all("t6");
    press(4'b0010, 4'h0);
    press(4'b0011, 4'h9);
    check_all("t6_next_beats_digit");

    // Random button traffic
    for (int k = 0; k < 80; k++) begin
      int         r;
      logic [3:0] m;
      r = int'($urandom_range(0, 99));
      if (r < 45)      m = 4'b0001;
      else if (r < 65) m = 4'b0010;
      else if (r < 85) m = 4'b0100;
      else if (r < 90) m = 4'b1000;
      else             m = 4'($urandom_range(1, 15));
      press(m, 4'($urandom_range(0, 15)));
      check_all($sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
